instruction_fetch: RTL

//   MIPS Instruction Fetch stage with IF/ID pipeline register; sits directly upstream of the

---
 rtl/instruction_fetch.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch
// Brief   : MIPS IF stage with IF/ID register, ready-handshake fetch port,
//           ID stall support and branch/jump redirect with flush.
// Revision: 1.0
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jump,
    input  logic [25:0] jumpAddress,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instruction32,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4,
    output logic        valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_en_q;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] target_q, target_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        fetch_done;

    always_comb begin
        redirect        = branchTaken | jump;
        redirect_target = branchTaken ? {branchTarget[31:2], 2'b00}
                                      : {pc_plus4_q[31:28], jumpAddress, 2'b00};
        imemReq         = req_en_q && (state_q != S_HOLD);
        imemAddr        = pc_q;
        fetch_done      = imemReq & imemReady;

        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        skid_d     = skid_q;
        target_d   = target_q;

        case (state_q)
            S_FETCH: begin
                if (redirect && (fetch_done || !req_en_q)) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                end else if (fetch_done) begin
                    if (stall) begin
                        skid_d  = imemData;
                        state_d = S_HOLD;
                    end else begin
                        instr_d    = imemData;
                        pc_out_d   = pc_q;
                        pc_plus4_d = pc_q + 32'd4;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    // Request must stay stable until accepted, so park the target.
                    target_d = redirect_target;
                    valid_d  = 1'b0;
                    instr_d  = NOP_WORD;
                    state_d  = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    instr_d    = skid_q;
                    pc_out_d   = pc_q;
                    pc_plus4_d = pc_q + 32'd4;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                valid_d = 1'b0;
                instr_d = NOP_WORD;
                if (redirect) begin
                    target_d = redirect_target;
                end
                if (fetch_done) begin
                    pc_d    = redirect ? redirect_target : target_q;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_en_q   <= 1'b0;
            instr_q    <= NOP_WORD;
            pc_out_q   <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
            skid_q     <= 32'd0;
            target_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_en_q   <= 1'b1;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            skid_q     <= skid_d;
            target_q   <= target_d;
        end
    end

    assign instruction32 = instr_q;
    assign pcOut         = pc_out_q;
    assign pcPlus4       = pc_plus4_q;
    assign valid         = valid_q;

endmodule
`default_nettype wire
